// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// slave is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_rd, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_rd, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the LC3 data memory port between the
// MemAccess path (m0) and the debug/preload loader (m1).
//
// state | meaning
// IDLE  | no access in flight; winner's gnt is combinational
// ISSUE | registered mem_en strobe for the latched access
// WAIT  | MEM_LAT cycles of memory latency; read data captured on the last
// RESP  | one-cycle done to the winner; round-robin pointer flips
module dmem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic          busy
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              any_req;
  logic              pick1;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              gnt0, gnt1, done0, done1;

  // rr_q set means m1 is favoured when both ports request
  always_comb begin
    any_req   = bus.m0_req | bus.m1_req;
    pick1     = bus.m1_req & (~bus.m0_req | rr_q);
    win_we    = pick1 ? bus.m1_we    : bus.m0_we;
    win_addr  = pick1 ? bus.m1_addr  : bus.m0_addr;
    win_wdata = pick1 ? bus.m1_wdata : bus.m0_wdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt0       = ~pick1;
          gnt1       = pick1;
          id_d       = pick1;
          we_d       = win_we;
          addr_d     = win_addr;
          wdata_d    = win_wdata;
          mem_en_d   = 1'b1;
          mem_rd_d   = ~win_we;
          mem_addr_d = win_addr;
          mem_din_d  = win_wdata;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (id_q) rdata1_d = bus.mem_dout;
            else      rdata0_d = bus.mem_dout;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        done0   = ~id_q;
        done1   = id_q;
        rr_d    = ~id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_done  = done0;
  assign bus.m1_done  = done1;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance A (MEM_LAT=1) with a behavioural
// memory, instance B (MEM_LAT=3) driven by hand to probe the capture cycle.
module tb_dmem_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy_a, busy_b;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .busy(busy_a)
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B)) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  int          gnt_hist[$];
  logic [15:0] mem_a [int];
  int          cyc     = 0;
  int          gnt_cyc = 0;
  logic [15:0] shadow0 = '0;
  logic [15:0] shadow1 = '0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (mem_a.exists(int'(a))) return mem_a[int'(a)];
    return 16'h0000;
  endfunction

  // memory model for A: read data valid only in the cycle LAT_A after mem_en
  bit          pend_a = 1'b0;
  int          age_a  = 0;
  logic [15:0] raddr_a = '0;
  always @(negedge clock) begin
    if (!reset) begin
      pend_a = 1'b0;
      mem_a[32'h3000] = 16'h1234;
      bus_a.mem_dout = 16'hDEAD;
    end else begin
      if (bus_a.mem_en) begin
        if (!bus_a.mem_rd) mem_a[int'(bus_a.mem_addr)] = bus_a.mem_din;
        else begin pend_a = 1'b1; age_a = 0; raddr_a = bus_a.mem_addr; end
      end else if (pend_a) age_a++;
      if (pend_a && age_a == LAT_A) begin
        bus_a.mem_dout = mem_val(raddr_a);
        pend_a = 1'b0;
      end else begin
        bus_a.mem_dout = ~mem_val(raddr_a) ^ 16'h0F0F;
      end
    end
  end

  always @(negedge clock) begin
    txn_t t;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      shadow0 = '0;
      shadow1 = '0;
    end else begin
      if (bus_a.m0_gnt | bus_a.m1_gnt) begin
        chk("gnt_both", bus_a.m0_gnt & bus_a.m1_gnt, 0);
        chk("gnt_in_idle", busy_a, 0);
        if (exp_q.size() == 0) chk("gnt_unexp", {bus_a.m0_gnt, bus_a.m1_gnt}, 0);
        else chk("gnt_port", bus_a.m1_gnt, exp_q[0].port);
        gnt_cyc = cyc;
        gnt_hist.push_back(cyc);
      end
      if (bus_a.mem_en) begin
        if (exp_q.size() == 0) chk("en_unexp", bus_a.mem_en, 0);
        else begin
          chk("en_lat", cyc - gnt_cyc, 1);
          chk("mem_rd", bus_a.mem_rd, !exp_q[0].we);
          chk("mem_addr", bus_a.mem_addr, exp_q[0].addr);
          if (exp_q[0].we) chk("mem_din", bus_a.mem_din, exp_q[0].wdata);
        end
      end
      if (bus_a.m0_done | bus_a.m1_done) begin
        if (exp_q.size() == 0) chk("done_unexp", {bus_a.m0_done, bus_a.m1_done}, 0);
        else begin
          t = exp_q.pop_front();
          chk("done_both", bus_a.m0_done & bus_a.m1_done, 0);
          chk("done_port", bus_a.m1_done, t.port);
          chk("done_lat", cyc - gnt_cyc, LAT_A + 2);
          if (!t.we) begin
            if (t.port) shadow1 = t.rdata;
            else        shadow0 = t.rdata;
          end
          chk("rdata0", bus_a.m0_rdata, shadow0);
          chk("rdata1", bus_a.m1_rdata, shadow1);
        end
      end
    end
  end

  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (p) begin
      bus_a.m1_req = req; bus_a.m1_we = we; bus_a.m1_addr = addr; bus_a.m1_wdata = wdata;
    end else begin
      bus_a.m0_req = req; bus_a.m0_we = we; bus_a.m0_addr = addr; bus_a.m0_wdata = wdata;
    end
  endtask

  task automatic push_txn(input bit p, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata);
    txn_t t;
    t.port  = p;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? 16'h0000 : mem_val(addr);
    exp_q.push_back(t);
  endtask

  task automatic wait_gnt(input bit p, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); #1;
      if ((p ? bus_a.m1_gnt : bus_a.m0_gnt) == 1'b1) begin at = cyc; break; end
    end
    if (at < 0) chk("gnt_timeout", p ? bus_a.m1_gnt : bus_a.m0_gnt, 1);
  endtask

  task automatic wait_any(output bit p);
    bit seen = 1'b0;
    p = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); #1;
      if (bus_a.m0_gnt | bus_a.m1_gnt) begin p = bus_a.m1_gnt; seen = 1'b1; break; end
    end
    if (!seen) chk("any_gnt_timeout", bus_a.m0_gnt | bus_a.m1_gnt, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    if (exp_q.size() != 0) chk("done_timeout", exp_q.size(), 0);
  endtask

  task automatic run_txn(input bit p, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata);
    int at;
    push_txn(p, we, addr, wdata);
    @(posedge clock); #1;
    set_port(p, 1'b1, we, addr, wdata);
    wait_gnt(p, at);
    @(posedge clock); #1;
    set_port(p, 1'b0, 1'b0, '0, '0);
    wait_drain();
    @(negedge clock);
    chk("idle_after_done", busy_a, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, base, n0, n1;
    bit p;

    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus_b.m0_req = 0; bus_b.m0_we = 0; bus_b.m0_addr = '0; bus_b.m0_wdata = '0;
    bus_b.m1_req = 0; bus_b.m1_we = 0; bus_b.m1_addr = '0; bus_b.m1_wdata = '0;
    bus_b.mem_dout = 16'hFF5A;

    #22;
    chk("rst_busy", busy_a, 0);
    chk("rst_mem", {bus_a.mem_en, bus_a.mem_rd, bus_a.mem_addr, bus_a.mem_din[13:0]}, 0);
    chk("rst_rdata", {bus_a.m0_rdata, bus_a.m1_rdata}, 0);
    @(negedge clock); reset = 1'b1;

    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000);
    run_txn(1'b1, 1'b1, 16'h4001, 16'hBEEF);

    // m1 raised during m0's ISSUE must wait for the IDLE after m0_done
    push_txn(1'b0, 1'b0, 16'h3000, 16'h0000);
    push_txn(1'b1, 1'b0, 16'h4001, 16'h0000);
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, 1'b0, 16'h3000, '0);
    wait_gnt(1'b0, t0);
    @(posedge clock); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b1, 1'b0, 16'h4001, '0);
    wait_gnt(1'b1, t1);
    chk("m1_deferred", t1 - t0, LAT_A + 3);
    @(posedge clock); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    wait_drain();

    run_txn(1'b0, 1'b1, 16'h3001, 16'h0A0A);

    // reset during WAIT of an m1 read
    push_txn(1'b1, 1'b0, 16'h3000, 16'h0000);
    @(posedge clock); #1;
    set_port(1'b1, 1'b1, 1'b0, 16'h3000, '0);
    wait_gnt(1'b1, t0);
    @(posedge clock); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #2;
    chk("pre_rst_busy", busy_a, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_gnt_done", {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_done, bus_a.m1_done}, 0);
    chk("arst_rdata0", bus_a.m0_rdata, 0);
    chk("arst_rdata1", bus_a.m1_rdata, 0);
    chk("arst_mem", {bus_a.mem_en, bus_a.mem_rd}, 0);
    chk("arst_mem_bus", {bus_a.mem_addr, bus_a.mem_din}, 0);
    @(posedge clock); @(posedge clock);
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      chk("no_done_after_rst", {bus_a.m0_done, bus_a.m1_done}, 0);
    end

    // both ports hold req: expect m0, m1, m0, m1
    base = gnt_hist.size();
    push_txn(1'b0, 1'b0, 16'h3000, 16'h0000);
    push_txn(1'b1, 1'b0, 16'h4001, 16'h0000);
    push_txn(1'b0, 1'b1, 16'h3002, 16'h5555);
    push_txn(1'b1, 1'b0, 16'h3000, 16'h0000);
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, 1'b0, 16'h3000, '0);
    set_port(1'b1, 1'b1, 1'b0, 16'h4001, '0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(p);
      @(posedge clock); #1;
      if (!p) begin
        if (n0 == 0) set_port(1'b0, 1'b1, 1'b1, 16'h3002, 16'h5555);
        else         set_port(1'b0, 1'b0, 1'b0, '0, '0);
        n0++;
      end else begin
        if (n1 == 0) set_port(1'b1, 1'b1, 1'b0, 16'h3000, '0);
        else         set_port(1'b1, 1'b0, 1'b0, '0, '0);
        n1++;
      end
    end
    wait_drain();
    if (gnt_hist.size() >= base + 4) begin
      for (int i = 0; i < 3; i++)
        chk("gnt_spacing", gnt_hist[base+i+1] - gnt_hist[base+i], LAT_A + 3);
    end else begin
      chk("gnt_count", gnt_hist.size() - base, 4);
    end
    chk("wr_landed", mem_val(16'h3002), 16'h5555);

    // instance B, MEM_LAT=3: only mem_dout of the last WAIT cycle is captured
    @(posedge clock); #1;
    bus_b.m0_req = 1'b1; bus_b.m0_we = 1'b0; bus_b.m0_addr = 16'h0050;
    @(negedge clock);
    chk("b_gnt", bus_b.m0_gnt, 1);
    @(posedge clock); #1;
    bus_b.m0_req = 1'b0;
    @(negedge clock);
    chk("b_mem_en", {bus_b.mem_en, bus_b.mem_rd}, 2'b11);
    chk("b_mem_addr", bus_b.mem_addr, 16'h0050);
    @(negedge clock);
    chk("b_early_done_t2", bus_b.m0_done, 0);
    bus_b.mem_dout = 16'h1111;
    @(negedge clock);
    chk("b_early_done_t3", bus_b.m0_done, 0);
    bus_b.mem_dout = 16'h2222;
    @(negedge clock);
    chk("b_early_done_t4", bus_b.m0_done, 0);
    bus_b.mem_dout = 16'h00A5;
    @(negedge clock);
    chk("b_done_t5", bus_b.m0_done, 1);
    chk("b_rdata", bus_b.m0_rdata, 16'h00A5);
    bus_b.mem_dout = 16'h3333;
    @(negedge clock);
    chk("b_done_drop", bus_b.m0_done, 0);
    chk("b_idle", busy_b, 0);
    chk("b_rdata_hold", bus_b.m0_rdata, 16'h00A5);
    chk("b_m1_rdata", bus_b.m1_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single LC3 data memory port between two requesters.
- Requester 0 is the LC3 MemAccess/store path. Requester 1 is the debug/preload loader.
- Sequences each access as request, issue, fixed-latency wait, then response.
- Drives the data memory signals (Data_addr, Data_din, Data_rd, enable) that the data_memory UVMF agent monitors.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_dout valid (must be >= 1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 access request; held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  access address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  combinational grant, one cycle.
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data; valid while m0_done is high on a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: identical to the m0 set, for requester 1.
- mem_en  out  1  memory access strobe, one cycle.
- mem_rd  out  1  1 = read, 0 = write (LC3 Data_rd polarity).
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE; counter to 0.
  - Round-robin pointer favours m0.
  - All outputs 0, including rdata registers and mem_* outputs.
  - Any in-flight transaction is discarded; no done pulse follows reset release.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, the winner's gnt goes high combinationally in that cycle (cycle T).
  - On the edge ending cycle T, latch winner id, we, addr, wdata; go to ISSUE. No req: stay in IDLE.
- Arbitration:
  - Single request wins.
  - Both requesting: the port not granted last wins (round-robin); after reset, m0 wins first.
  - Never both gnt in the same cycle. gnt is only ever high in IDLE.
- ISSUE (cycle T+1):
  - mem_en=1; mem_rd=~we; mem_addr and mem_din from the latched values.
  - mem_* outputs are registered and zero outside ISSUE.
- WAIT (cycles T+2 .. T+1+MEM_LAT):
  - Counter runs MEM_LAT cycles.
  - In the last WAIT cycle, a read captures mem_dout into the winner's rdata register.
- RESP (cycle T+2+MEM_LAT):
  - Winner's done=1 for one cycle; pointer updated; then IDLE.
  - Writes also pulse done.
  - A port's rdata updates only on its own reads and holds otherwise.
- Throughput: one access per MEM_LAT+3 cycles. Latency from gnt to done: MEM_LAT+2 cycles.
- req/gnt protocol:
  - Requester holds req and payload stable until gnt.
  - Requester may drop or re-raise req in the cycle after gnt.
  - req high during ISSUE/WAIT/RESP is not granted; it waits for IDLE.
  - req dropped before gnt: no transaction.
- Address/data wrap: none; values pass through unmodified.

Test Plan:
1. m0 read, addr=0x3000, memory holds 0x1234, MEM_LAT=1, gnt at T -> mem_en=1, mem_rd=1, mem_addr=0x3000 at T+1; m0_done=1, m0_rdata=0x1234 at T+3; busy low at T+4.
2. m1 write, addr=0x4001, wdata=0xBEEF -> mem_en=1, mem_rd=0, mem_din=0xBEEF at T+1; m1_done at T+3; m1_rdata unchanged.
3. m0 and m1 both hold req continuously from reset, 4 accesses -> grant order m0, m1, m0, m1; gnt pulses 4 cycles apart; never both gnt high.
4. MEM_LAT=3, m0 read of 0x00A5 -> done at T+5 with rdata=0x00A5; a value driven on mem_dout before T+4 is not captured.
5. Reset asserted during WAIT of an m1 read -> all outputs 0 immediately; after release, no m1_done; next simultaneous request grants m0.
6. m1 req raised during an m0 ISSUE -> no m1_gnt until the IDLE cycle after m0_done; m1 is then granted in that first IDLE cycle.
